id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand selection for the 5-stage RV32I core.
//  Captures decoded instructions from ID and resolves forwarding from EX/MEM and MEM/WB.
//  Drives SrcA/SrcB/Operation straight into the ALU and carries control/store data to EX/MEM.
//  Also flags load-use hazards back to the hazard/stall logic.
// PARAMETERS
//  DATA_WIDTH     32  datapath width
//  OPCODE_LENGTH  4   ALU operation code width
//  REG_ADDR_W     5   register index width
// PORTS
//  clk              in   1            rising-edge clock
//  reset            in   1            synchronous, active-high
//  stall            in   1            hold stage contents
//  flush            in   1            replace stage contents with bubble
//  id_valid         in   1            ID slot holds a real instruction
//  id_pc            in   DATA_WIDTH   instruction PC
//  id_rs1_data      in   DATA_WIDTH   regfile read port 1
//  id_rs2_data      in   DATA_WIDTH   regfile read port 2
//  id_imm           in   DATA_WIDTH   sign-extended immediate
//  id_rs1,id_rs2    in   REG_ADDR_W   source indices
//  id_rd            in   REG_ADDR_W   destination index
//  id_alu_op        in   OPCODE_LENGTH ALU operation code
//  id_alu_src       in   1            1: SrcB = imm
//  id_a_sel_pc      in   1            1: SrcA = pc (AUIPC/JAL)
//  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in 1 each  control bits
//  exm_reg_write    in   1            EX/MEM writes a register
//  exm_rd           in   REG_ADDR_W   EX/MEM destination
//  exm_result       in   DATA_WIDTH   EX/MEM ALU result
//  mwb_reg_write    in   1            MEM/WB writes a register
//  mwb_rd           in   REG_ADDR_W   MEM/WB destination
//  mwb_result       in   DATA_WIDTH   MEM/WB writeback value
//  SrcA, SrcB       out  DATA_WIDTH   ALU operands (combinational from stage regs)
//  Operation        out  OPCODE_LENGTH ALU operation (registered)
//  ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  registered
//  ex_store_data    out  DATA_WIDTH   forwarded rs2 value for stores
//  load_use_hazard  out  1            combinational; ID must stall one cycle
// BEHAVIOUR
//  - Register update priority each clk edge: reset > flush > stall > load from ID.
//  - Reset and flush both load a bubble: valid=0, all control=0, Operation=4'b0000,
//    rd/rs=0, pc/data/imm=0. Hence SrcA=SrcB=0 and ex_store_data=0 after reset.
//  - Stall with no flush holds every register. Forwarding still re-evaluates live inputs.
//  - Latency: ID inputs visible on outputs 1 cycle later.
//  - Forward rs1: EX/MEM if exm_reg_write & exm_rd!=0 & exm_rd==rs1; else MEM/WB if the
//    same test passes on mwb_*; else the registered rs1_data. rs2 uses the same rule.
//    EX/MEM wins when both sources match. x0 is never forwarded.
//  - SrcA = a_sel_pc ? pc : fwd_rs1. SrcB = alu_src ? imm : fwd_rs2.
//  - ex_store_data = fwd_rs2 regardless of alu_src.
//  - load_use_hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid &
//    (id_rs1==ex_rd | id_rs2==ex_rd). It is independent of stall/flush.
//  - Invalid (bubble) entries never assert ex_reg_write/ex_mem_write.
//  - No arithmetic here; widths pass through unchanged.
// STRUCTURE
//  - pipeline_pkg: alu_op_t constants (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLL=3, ALU_SRL=4,
//    ALU_SUB=5, ALU_SRA=6, ALU_SLT=7, ALU_BEQ=8, ALU_BNE=9, ALU_BLT=10, ALU_BGE=11,
//    ALU_XOR=12, ALU_LUI=13); fwd_sel_t {FWD_NONE, FWD_MWB, FWD_EXM}; id_ex_t struct.
//  - Sub-module forwarding_unit: (rs, exm_*, mwb_*) -> fwd_sel_t.
//    It is instantiated twice, once for rs1 and once for rs2.
// TESTING
//  1. reset=1 for 2 cycles with random ID inputs -> all outputs 0, Operation=0, ex_valid=0.
//  2. Load id_rs1_data=5, imm=7, alu_src=1, alu_op=2, no forwarding
//     -> next cycle SrcA=5, SrcB=7, Operation=2.
//  3. rs1=3; exm_rd=3 with exm_result=0xAA; mwb_rd=3 with mwb_result=0xBB -> SrcA=0xAA.
//     Drop exm_reg_write -> SrcA=0xBB.
//  4. rs2=0 with exm_rd=0, exm_reg_write=1 -> SrcB = registered rs2_data, no forwarding.
//  5. stall=1 for 3 cycles with changing ID inputs -> registered outputs hold.
//     Then stall=flush=1 -> bubble loaded.
//  6. EX holds lw x5, ID presents rs2=5 with id_valid=1 -> load_use_hazard=1.
//     Same case with id_valid=0 -> load_use_hazard=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the RV32I ID/EX stage: ALU op codes, forwarding selects, stage record.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 4;
  localparam int RA_W = 5;

  typedef enum logic [OP_W-1:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SRL = 4'd4,
    ALU_SUB = 4'd5,
    ALU_SRA = 4'd6,
    ALU_SLT = 4'd7,
    ALU_BEQ = 4'd8,
    ALU_BNE = 4'd9,
    ALU_BLT = 4'd10,
    ALU_BGE = 4'd11,
    ALU_XOR = 4'd12,
    ALU_LUI = 4'd13
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MWB  = 2'd1,
    FWD_EXM  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    alu_op_t         alu_op;
    logic            alu_src;
    logic            a_sel_pc;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_t sel,
                                              input logic [XLEN-1:0] exm,
                                              input logic [XLEN-1:0] mwb,
                                              input logic [XLEN-1:0] own);
    case (sel)
      FWD_EXM: return exm;
      FWD_MWB: return mwb;
      default: return own;
    endcase
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Picks the freshest producer of one source register; EX/MEM beats MEM/WB, x0 never forwards.
module forwarding_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = RA_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  mwb_reg_write,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  output fwd_sel_t              sel
);

  always_comb begin
    sel = FWD_NONE;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs)) begin
      sel = FWD_EXM;
    end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs)) begin
      sel = FWD_MWB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
module id_ex_operand_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int OPCODE_LENGTH = OP_W,
  parameter int REG_ADDR_W    = RA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_a_sel_pc,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_mem_to_reg,
  input  logic                     exm_reg_write,
  input  logic [REG_ADDR_W-1:0]    exm_rd,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic                     mwb_reg_write,
  input  logic [REG_ADDR_W-1:0]    mwb_rd,
  input  logic [DATA_WIDTH-1:0]    mwb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_mem_to_reg,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     load_use_hazard
);

  id_ex_t   stage_d;
  id_ex_t   stage_q;
  fwd_sel_t fwd_a_sel;
  fwd_sel_t fwd_b_sel;
  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;

  // Control bits are qualified by id_valid so a bubble can never write state downstream.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = ID_EX_BUBBLE;
    end else if (!stall) begin
      stage_d.valid      = id_valid;
      stage_d.pc         = id_pc;
      stage_d.rs1_data   = id_rs1_data;
      stage_d.rs2_data   = id_rs2_data;
      stage_d.imm        = id_imm;
      stage_d.rs1        = id_rs1;
      stage_d.rs2        = id_rs2;
      stage_d.rd         = id_rd;
      stage_d.alu_op     = alu_op_t'(id_alu_op);
      stage_d.alu_src    = id_alu_src;
      stage_d.a_sel_pc   = id_a_sel_pc;
      stage_d.reg_write  = id_valid & id_reg_write;
      stage_d.mem_read   = id_valid & id_mem_read;
      stage_d.mem_write  = id_valid & id_mem_write;
      stage_d.mem_to_reg = id_valid & id_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= ID_EX_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  // EX stage: operands resolved from live EX/MEM and MEM/WB results, even while stalled.
  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs            (stage_q.rs1),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .sel           (fwd_a_sel)
  );

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs            (stage_q.rs2),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .sel           (fwd_b_sel)
  );

  always_comb begin
    fwd_rs1 = fwd_mux(fwd_a_sel, exm_result, mwb_result, stage_q.rs1_data);
    fwd_rs2 = fwd_mux(fwd_b_sel, exm_result, mwb_result, stage_q.rs2_data);
  end

  assign SrcA          = stage_q.a_sel_pc ? stage_q.pc : fwd_rs1;
  assign SrcB          = stage_q.alu_src ? stage_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign Operation     = stage_q.alu_op;
  assign ex_valid      = stage_q.valid;
  assign ex_rd         = stage_q.rd;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;
  assign ex_mem_to_reg = stage_q.mem_to_reg;

  // A load in EX cannot feed the instruction now in ID without one stall cycle.
  assign load_use_hazard = stage_q.valid & stage_q.mem_read & (stage_q.rd != '0) & id_valid &
                           ((id_rs1 == stage_q.rd) | (id_rs2 == stage_q.rd));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed plus randomized bench for id_ex_operand_stage against a behavioural stage model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_a_sel_pc, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;
  logic [4:0]  ex_rd;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of what the stage currently holds (the instruction now in EX)
  logic        m_valid, m_alu_src, m_a_pc, m_rw, m_mr, m_mw, m_m2r;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_op;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_a_sel_pc(id_a_sel_pc), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] own);
    if (rs == 5'd0) return own;
    if (exm_reg_write && exm_rd == rs) return exm_result;
    if (mwb_reg_write && mwb_rd == rs) return mwb_result;
    return own;
  endfunction

  task automatic model_clear();
    {m_valid, m_alu_src, m_a_pc, m_rw, m_mr, m_mw, m_m2r} = '0;
    {m_pc, m_rs1d, m_rs2d, m_imm} = '0;
    {m_rs1, m_rs2, m_rd} = '0;
    m_op = '0;
  endtask

  task automatic clear_in();
    {reset, stall, flush, id_valid} = '0;
    {id_pc, id_rs1_data, id_rs2_data, id_imm} = '0;
    {id_rs1, id_rs2, id_rd} = '0;
    id_alu_op = '0;
    {id_alu_src, id_a_sel_pc, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = '0;
    {exm_reg_write, mwb_reg_write} = '0;
    {exm_rd, mwb_rd} = '0;
    {exm_result, mwb_result} = '0;
  endtask

  task automatic rand_in();
    id_valid = 1'($urandom);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(3, 0)); id_rs2 = 5'($urandom_range(3, 0));
    id_rd = 5'($urandom_range(3, 0));
    id_alu_op = 4'($urandom_range(13, 0));
    id_alu_src = 1'($urandom); id_a_sel_pc = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    exm_reg_write = 1'($urandom); mwb_reg_write = 1'($urandom);
    exm_rd = 5'($urandom_range(3, 0)); mwb_rd = 5'($urandom_range(3, 0));
    exm_result = $urandom; mwb_result = $urandom;
  endtask

  // Advance one clock, updating the model with the same reset > flush > stall > load order
  task automatic tick();
    logic load;
    load = !reset && !flush && !stall;
    @(posedge clk);
    if (reset || flush) begin
      model_clear();
    end else if (load) begin
      m_valid = id_valid; m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
      m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_op = id_alu_op;
      m_alu_src = id_alu_src; m_a_pc = id_a_sel_pc;
      m_rw = id_valid && id_reg_write; m_mr = id_valid && id_mem_read;
      m_mw = id_valid && id_mem_write; m_m2r = id_valid && id_mem_to_reg;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] a, b, sd;
    logic haz;
    #1;
    sd = ref_operand(m_rs2, m_rs2d);
    a  = m_a_pc ? m_pc : ref_operand(m_rs1, m_rs1d);
    b  = m_alu_src ? m_imm : sd;
    haz = m_valid && m_mr && (m_rd != 0) && id_valid && (id_rs1 == m_rd || id_rs2 == m_rd);
    chk({tag, ".SrcA"}, SrcA, a);
    chk({tag, ".SrcB"}, SrcB, b);
    chk({tag, ".store"}, ex_store_data, sd);
    chk({tag, ".op"}, 32'(Operation), 32'(m_op));
    chk({tag, ".ctl"}, {26'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                        load_use_hazard}, {26'd0, m_valid, m_rw, m_mr, m_mw, m_m2r, haz});
    chk({tag, ".rd"}, 32'(ex_rd), 32'(m_rd));
  endtask

  initial begin
    clear_in();
    model_clear();

    // Reset with random ID and forwarding traffic
    rand_in(); reset = 1'b1; tick();
    rand_in(); reset = 1'b1; tick();
    check_all("reset");
    chk("reset.zero", {SrcA | SrcB | ex_store_data, 28'd0, Operation}, 32'd0);
    chk("reset.valid", 32'(ex_valid), 32'd0);

    // Basic load, 1-cycle latency
    clear_in();
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 4; id_rs1_data = 5; id_imm = 7;
    id_alu_src = 1; id_alu_op = 4'd2; id_reg_write = 1;
    tick();
    check_all("basic");
    chk("basic.SrcA", SrcA, 32'd5);
    chk("basic.SrcB", SrcB, 32'd7);
    chk("basic.op", 32'(Operation), 32'd2);

    // Forwarding priority
    clear_in();
    id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h11; id_rd = 6;
    tick();
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'hAA;
    mwb_reg_write = 1; mwb_rd = 3; mwb_result = 32'hBB;
    check_all("fwd_both");
    chk("fwd.exm_wins", SrcA, 32'hAA);
    exm_reg_write = 0;
    check_all("fwd_mwb");
    chk("fwd.mwb", SrcA, 32'hBB);
    mwb_reg_write = 0;
    check_all("fwd_none");
    chk("fwd.none", SrcA, 32'h11);

    // x0 never forwards
    clear_in();
    id_valid = 1; id_rs2 = 0; id_rs2_data = 32'h33;
    tick();
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'hDEAD;
    check_all("x0");
    chk("x0.SrcB", SrcB, 32'h33);

    // Stall holds, then flush overrides stall
    clear_in();
    id_valid = 1; id_alu_op = 4'd5; id_rd = 9; id_reg_write = 1; id_mem_write = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_in(); stall = 1;
      tick();
      check_all("stall");
      chk("stall.op", 32'(Operation), 32'd5);
      chk("stall.rd", 32'(ex_rd), 32'd9);
    end
    rand_in(); stall = 1; flush = 1;
    tick();
    check_all("flush");
    chk("flush.valid", 32'({ex_valid, ex_reg_write, ex_mem_write}), 32'd0);

    // Load-use hazard
    clear_in();
    id_valid = 1; id_rd = 5; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    tick();
    id_valid = 1; id_rs1 = 7; id_rs2 = 5; id_rd = 8; id_mem_read = 0;
    check_all("lu_hit");
    chk("lu.hit", 32'(load_use_hazard), 32'd1);
    id_valid = 0;
    check_all("lu_novalid");
    chk("lu.novalid", 32'(load_use_hazard), 32'd0);

    // Randomized traffic
    clear_in();
    for (int i = 0; i < 400; i++) begin
      rand_in();
      reset = ($urandom_range(31, 0) == 0);
      flush = ($urandom_range(7, 0) == 0);
      stall = ($urandom_range(5, 0) == 0);
      tick();
      check_all("rand");
      exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(3, 0)); exm_result = $urandom;
      check_all("rand_live");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
